// File: rtl/handshake_tx_if.sv
// Valid/ready source port plus req/ack handshake pins for handshake_tx.
// The err pin exists only when HANDSHAKE_TIMEOUT_EN is defined.
interface handshake_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  req_out;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  ack_in;
   logic                  busy;
   logic                  done;
`ifdef HANDSHAKE_TIMEOUT_EN
   logic                  err;

   modport master (
      input  in_data, in_valid, ack_in,
      output in_ready, req_out, data_out, busy, done, err
   );
   modport slave (
      output in_data, in_valid, ack_in,
      input  in_ready, req_out, data_out, busy, done, err
   );
`else
   modport master (
      input  in_data, in_valid, ack_in,
      output in_ready, req_out, data_out, busy, done
   );
   modport slave (
      output in_data, in_valid, ack_in,
      input  in_ready, req_out, data_out, busy, done
   );
`endif
endinterface

// File: rtl/handshake_tx.sv
// Source side of a 4-phase req/ack crossing: one word per handshake, ack synchronized locally.
// Optional per-phase timeout with err pulse is compiled in by defining HANDSHAKE_TIMEOUT_EN.
module handshake_tx #(
   parameter int DATA_WIDTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic          clk,
   input  logic          rst,
   handshake_tx_if.master hs
);
   typedef enum logic [1:0] {
      S_IDLE        = 2'd0,
      S_REQ_HI      = 2'd1,
      S_ACK_WAIT_LO = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_nxt_state;
   logic [SYNC_STAGES-1:0]  r_sync;
   logic                    w_ack_s;
   logic                    w_ack_s_nxt;
   logic [DATA_WIDTH-1:0]   r_data;
   logic                    r_req;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_rdy;
   logic                    w_req;
   logic                    w_busy;
   logic                    w_done;
   logic                    w_load;
   logic                    w_rdy;

   assign w_ack_s     = r_sync[SYNC_STAGES-1];
   // in_ready is registered, so it is decoded from the values state and ack_s take next cycle
   assign w_ack_s_nxt = r_sync[SYNC_STAGES-2];

`ifdef HANDSHAKE_TIMEOUT_EN
   localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          r_err;
   logic          r_tmo;
   logic          w_err;
   logic          w_tmo;
   logic          w_tmo_hit;

   assign w_tmo_hit = (r_cnt == TMO_LAST);
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

   always_comb begin
      w_nxt_state = r_state;
      w_req       = r_req;
      w_busy      = r_busy;
      w_done      = 1'b0;
      w_load      = 1'b0;
`ifdef HANDSHAKE_TIMEOUT_EN
      w_err       = 1'b0;
      w_tmo       = r_tmo;
`endif
      case (r_state)
         S_IDLE: begin
            if (hs.in_valid && r_rdy) begin
               w_load      = 1'b1;
               w_req       = 1'b1;
               w_busy      = 1'b1;
               w_nxt_state = S_REQ_HI;
`ifdef HANDSHAKE_TIMEOUT_EN
               w_tmo       = 1'b0;
`endif
            end
         end
         S_REQ_HI: begin
            if (w_ack_s) begin
               w_req       = 1'b0;
               w_nxt_state = S_ACK_WAIT_LO;
            end
`ifdef HANDSHAKE_TIMEOUT_EN
            else if (w_tmo_hit) begin
               // abandoned request: still wait for ack low, but suppress done
               w_req       = 1'b0;
               w_err       = 1'b1;
               w_tmo       = 1'b1;
               w_nxt_state = S_ACK_WAIT_LO;
            end
`endif
         end
         S_ACK_WAIT_LO: begin
            if (!w_ack_s) begin
               w_busy      = 1'b0;
               w_nxt_state = S_IDLE;
`ifdef HANDSHAKE_TIMEOUT_EN
               w_done      = !r_tmo;
`else
               w_done      = 1'b1;
`endif
            end
`ifdef HANDSHAKE_TIMEOUT_EN
            else if (w_tmo_hit) begin
               w_err       = 1'b1;
               w_busy      = 1'b0;
               w_nxt_state = S_IDLE;
            end
`endif
         end
         default: begin
            w_req       = 1'b0;
            w_busy      = 1'b0;
            w_nxt_state = S_IDLE;
         end
      endcase
      w_rdy = (w_nxt_state == S_IDLE) && !w_ack_s_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sync  <= '0;
         r_data  <= '0;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_rdy   <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_sync  <= {r_sync[SYNC_STAGES-2:0], hs.ack_in};
         r_req   <= w_req;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_rdy   <= w_rdy;
         if (w_load) r_data <= hs.in_data;
      end
   end

`ifdef HANDSHAKE_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
         r_tmo <= 1'b0;
      end else begin
         r_err <= w_err;
         r_tmo <= w_tmo;
         if (w_nxt_state != r_state)
            r_cnt <= '0;
         else if (r_state != S_IDLE)
            r_cnt <= r_cnt + CW'(1);
      end
   end

   assign hs.err = r_err;
`endif

   assign hs.in_ready = r_rdy;
   assign hs.req_out  = r_req;
   assign hs.data_out = r_data;
   assign hs.busy     = r_busy;
   assign hs.done     = r_done;
endmodule

// File: tb/tb_handshake_tx.sv
// Directed bench for handshake_tx: reset, single transfer, back-to-back, stale ack, mid reset,
// and the timeout path when HANDSHAKE_TIMEOUT_EN is defined.
module tb_handshake_tx;
   localparam int DW  = 8;
   localparam int SS  = 2;
   localparam int TMO = 15;

   logic clk = 1'b0;
   logic rst;
   logic echo;
   logic ack_man;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   handshake_tx_if #(.DATA_WIDTH(DW)) hs();

   // echo mode models a zero-latency destination that mirrors req
   assign hs.ack_in = echo ? hs.req_out : ack_man;

   handshake_tx #(
      .DATA_WIDTH    (DW),
      .SYNC_STAGES   (SS),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hs (hs)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; echo = 1'b0; ack_man = 1'b0;
      hs.in_valid = 1'b0; hs.in_data = '0;
      repeat (3) tick();
      n_cmp++; if (hs.req_out  !== 1'b0) begin n_bad++; $display("FAIL reset_req_out got %b want 0", hs.req_out); end
      n_cmp++; if (hs.busy     !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", hs.busy); end
      n_cmp++; if (hs.done     !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", hs.done); end
      n_cmp++; if (hs.data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out got %h want 00", hs.data_out); end
      n_cmp++; if (hs.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", hs.in_ready); end
      rst = 1'b0;
      tick();
      n_cmp++; if (hs.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", hs.in_ready); end
   endtask

   task automatic test_single();
      int done_at = -1;
      int n_done  = 0;
      bit rdy_bad = 1'b0;
      echo = 1'b1;
      hs.in_data = 8'hA5; hs.in_valid = 1'b1;
      n_cmp++; if (hs.in_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", hs.in_ready); end
      tick();
      hs.in_valid = 1'b0; hs.in_data = 8'h00;
      n_cmp++; if (hs.data_out !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", hs.data_out); end
      n_cmp++; if (hs.req_out  !== 1'b1) begin n_bad++; $display("FAIL single_req got %b want 1", hs.req_out); end
      n_cmp++; if (hs.busy     !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", hs.busy); end
      // acceptance cycle is cycle 0, so cycle 7 is sampled 6 edges after the accepting edge
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (hs.done === 1'b1) begin
            n_done++;
            if (done_at < 0) done_at = k;
            if (hs.in_ready !== 1'b1 || hs.busy !== 1'b0) rdy_bad = 1'b1;
         end
      end
      n_cmp++; if (done_at !== 6) begin n_bad++; $display("FAIL single_done_time got %0d want 6", done_at); end
      n_cmp++; if (n_done  !== 1) begin n_bad++; $display("FAIL single_done_count got %0d want 1", n_done); end
      n_cmp++; if (rdy_bad !== 1'b0) begin n_bad++; $display("FAIL single_done_ready got %b want 0", rdy_bad); end
   endtask

   task automatic test_back_to_back();
      int acc_k   = -1;
      bit done_sn = 1'b0;
      bit bad     = 1'b0;
      bit got     = 1'b0;
      echo = 1'b1;
      hs.in_data = 8'h01; hs.in_valid = 1'b1;
      tick();
      hs.in_data = 8'h02;
      for (int k = 1; k <= 12 && acc_k < 0; k++) begin
         tick();
         if (hs.busy === 1'b1 && hs.data_out !== 8'h01) bad = 1'b1;
         if (hs.in_ready === 1'b1) begin acc_k = k; done_sn = hs.done; end
      end
      n_cmp++; if (acc_k   !== 6)    begin n_bad++; $display("FAIL b2b_ready_time got %0d want 6", acc_k); end
      n_cmp++; if (done_sn !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_on_done got %b want 1", done_sn); end
      tick();
      hs.in_valid = 1'b0;
      n_cmp++; if (hs.data_out !== 8'h02) begin n_bad++; $display("FAIL b2b_second_data got %h want 02", hs.data_out); end
      n_cmp++; if (hs.busy     !== 1'b1) begin n_bad++; $display("FAIL b2b_second_busy got %b want 1", hs.busy); end
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (hs.busy === 1'b1 && hs.data_out !== 8'h02) bad = 1'b1;
         if (hs.done === 1'b1) got = 1'b1;
      end
      n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL b2b_data_stable got %b want 0", bad); end
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done got %b want 1", got); end
   endtask

   task automatic test_stale_ack();
      bit bad = 1'b0;
      bit got = 1'b0;
      echo = 1'b0; ack_man = 1'b1; hs.in_valid = 1'b0;
      repeat (3) tick();
      n_cmp++; if (hs.in_ready !== 1'b0) begin n_bad++; $display("FAIL stale_ready got %b want 0", hs.in_ready); end
      hs.in_data = 8'h5A; hs.in_valid = 1'b1;
      repeat (4) begin
         tick();
         if (hs.req_out !== 1'b0 || hs.in_ready !== 1'b0 || hs.busy !== 1'b0) bad = 1'b1;
      end
      n_cmp++; if (bad !== 1'b0) begin n_bad++; $display("FAIL stale_no_request got %b want 0", bad); end
      ack_man = 1'b0;
      tick();
      n_cmp++; if (hs.in_ready !== 1'b0) begin n_bad++; $display("FAIL stale_ready_early got %b want 0", hs.in_ready); end
      tick();
      n_cmp++; if (hs.in_ready !== 1'b1) begin n_bad++; $display("FAIL stale_ready_release got %b want 1", hs.in_ready); end
      tick();
      hs.in_valid = 1'b0;
      n_cmp++; if (hs.req_out  !== 1'b1)  begin n_bad++; $display("FAIL stale_accept_req got %b want 1", hs.req_out); end
      n_cmp++; if (hs.data_out !== 8'h5A) begin n_bad++; $display("FAIL stale_accept_data got %h want 5a", hs.data_out); end
      echo = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (hs.done === 1'b1) got = 1'b1;
      end
      n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL stale_done got %b want 1", got); end
   endtask

   task automatic test_mid_reset();
      int n_done = 0;
      echo = 1'b0; ack_man = 1'b0;
      hs.in_data = 8'h3C; hs.in_valid = 1'b1;
      tick();
      hs.in_valid = 1'b0;
      n_cmp++; if (hs.req_out !== 1'b1) begin n_bad++; $display("FAIL midrst_req_before got %b want 1", hs.req_out); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (hs.req_out !== 1'b0) begin n_bad++; $display("FAIL midrst_req got %b want 0", hs.req_out); end
      n_cmp++; if (hs.busy    !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", hs.busy); end
      if (hs.done === 1'b1) n_done++;
      tick();
      n_cmp++; if (hs.in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", hs.in_ready); end
      for (int k = 1; k <= 6; k++) begin
         if (hs.done === 1'b1) n_done++;
         tick();
      end
      n_cmp++; if (n_done !== 0) begin n_bad++; $display("FAIL midrst_done_count got %0d want 0", n_done); end
   endtask

`ifdef HANDSHAKE_TIMEOUT_EN
   task automatic test_timeout();
      int err_at  = -1;
      int n_errp  = 0;
      int n_done  = 0;
      bit req_err = 1'b1;
      echo = 1'b0; ack_man = 1'b0;
      hs.in_data = 8'hC3; hs.in_valid = 1'b1;
      tick();
      hs.in_valid = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (hs.err === 1'b1) begin
            n_errp++;
            if (err_at < 0) begin err_at = k; req_err = hs.req_out; end
         end
         if (hs.done === 1'b1) n_done++;
      end
      n_cmp++; if (err_at   !== TMO)  begin n_bad++; $display("FAIL tmo_err_time got %0d want %0d", err_at, TMO); end
      n_cmp++; if (n_errp   !== 1)    begin n_bad++; $display("FAIL tmo_err_count got %0d want 1", n_errp); end
      n_cmp++; if (req_err  !== 1'b0) begin n_bad++; $display("FAIL tmo_req_at_err got %b want 0", req_err); end
      n_cmp++; if (n_done   !== 0)    begin n_bad++; $display("FAIL tmo_done_count got %0d want 0", n_done); end
      n_cmp++; if (hs.busy  !== 1'b0) begin n_bad++; $display("FAIL tmo_busy got %b want 0", hs.busy); end
      n_cmp++; if (hs.in_ready !== 1'b1) begin n_bad++; $display("FAIL tmo_ready got %b want 1", hs.in_ready); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stale_ack();
      test_mid_reset();
`ifdef HANDSHAKE_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/handshake_tx.md
# handshake_tx

Source-side initiator of a 4-phase req/ack handshake that carries one data word per transfer into another clock domain. Local logic offers a word through a valid/ready port. The block registers the word, raises `req_out` and holds the word stable. The destination returns `ack_in` asynchronously; the block synchronizes it internally with a flop chain before acting on it. The block sits beside the shutdown controller's synchronizers and drives requests and commands out of the controller's clock domain.

## Interface
- `DATA_WIDTH`, 8, width of the transferred word
- `SYNC_STAGES`, 2, flop stages on `ack_in`; legal range 2–4
- `TIMEOUT_CYCLES`, 1023, wait limit per handshake phase; used only when the timeout feature is compiled in

- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  DATA_WIDTH  word to send
- `in_valid`  in  1  `in_data` is offered
- `in_ready`  out  1  block accepts a word this cycle
- `req_out`  out  1  handshake request toward the destination domain; registered, glitch-free
- `data_out`  out  DATA_WIDTH  held word; registered
- `ack_in`  in  1  asynchronous acknowledge from the destination
- `busy`  out  1  a handshake is in progress
- `done`  out  1  one-cycle pulse when a handshake completes
- `err`  out  1  one-cycle pulse on timeout; only present when `HANDSHAKE_TIMEOUT_EN` is defined

## Operation
- `ack_in` passes through `SYNC_STAGES` flops to form `ack_s`. Only `ack_s` is used by the FSM.
- Reset values: all outputs are 0, the FSM is in IDLE, the sync chain is 0, and the timeout counter is 0.
- FSM states:
  - IDLE: `in_ready` = 1 only when `ack_s` == 0. If `in_valid && in_ready`, latch `in_data` into `data_out`, set `req_out` = 1 and `busy` = 1, and go to REQ_HI.
  - REQ_HI: hold `req_out` = 1. When `ack_s` == 1, clear `req_out` and go to ACK_WAIT_LO.
  - ACK_WAIT_LO: hold `req_out` = 0 and keep `data_out` stable. When `ack_s` == 0, pulse `done`, clear `busy` and go to IDLE.
- `data_out` changes only on acceptance in IDLE. Outside IDLE it ignores `in_data` and `in_valid`.
- If `ack_s` is stale-high in IDLE, for example after a destination glitch, `in_ready` stays 0 until `ack_s` falls. No request is issued.
- An `in_valid` that arrives in any state other than IDLE is not accepted. The source holds it, per valid/ready rules.
- `rst` asserted mid-handshake returns the block to IDLE and drops `req_out` on the next edge. The destination must tolerate the abandoned request.

## Timing
- Acceptance at edge N: `req_out` = 1 and `data_out` valid after edge N; `busy` = 1 after the same edge.
- `ack_in` rising: `ack_s` rises after `SYNC_STAGES` edges. `req_out` falls one edge later.
- `ack_in` falling: `ack_s` falls after `SYNC_STAGES` edges. `done` is high for the following cycle. `in_ready` is high in that same cycle.
- Minimum round trip with a 0-latency destination echo and `SYNC_STAGES` = 2 is 7 cycles from acceptance to next `in_ready`.
- `in_ready` is a registered-state decode with no combinational path from `in_valid`.

## Configuration
- `HANDSHAKE_TIMEOUT_EN` defined:
  - A counter of width clog2(`TIMEOUT_CYCLES`+1) clears on every state entry and increments each cycle in REQ_HI and ACK_WAIT_LO.
  - Count reaching `TIMEOUT_CYCLES` in REQ_HI: drop `req_out`, pulse `err` and go to ACK_WAIT_LO.
  - Count reaching `TIMEOUT_CYCLES` in ACK_WAIT_LO: pulse `err`, go to IDLE and clear `busy`. No `done` pulse is issued for that handshake.
- `HANDSHAKE_TIMEOUT_EN` undefined: no counter and no `err` port. Waits are unbounded.

## Test plan
- Reset: assert `rst` for 3 cycles -> `req_out`, `busy`, `done`, `data_out` and `in_ready` all 0. `in_ready` = 1 one cycle after release.
- Single transfer, ack echoed with 0 delay: `in_data` = 0xA5 accepted -> `data_out` = 0xA5 and `req_out` = 1 next cycle. `done` pulses once, 7 cycles after acceptance.
- Back-to-back, `in_valid` held high with 0x01 then 0x02: 0x02 is not accepted until the `done` cycle. `data_out` never changes while `busy` = 1.
- Stale ack: `ack_in` = 1 in IDLE with `in_valid` = 1 -> `in_ready` = 0 and no request. Drop `ack_in` -> `in_ready` = 1 `SYNC_STAGES` cycles later.
- Mid-handshake reset: `rst` pulsed in REQ_HI -> `req_out` = 0 and `busy` = 0 next cycle, with no `done` pulse.
- Timeout (`HANDSHAKE_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 15), `ack_in` held 0: `req_out` falls and `err` pulses 15 cycles after entering REQ_HI. The block returns to IDLE with no `done` pulse.
